// File: rtl/sm_sort_ctrl.sv
// Block bubble sorter for sign-magnitude words: LOAD -> SORT -> DRAIN, one shared >= compare per cycle.
// Optional SM_SORT_EARLY_EXIT_EN: finish SORT after the first pass with no swaps.

module sm_ge #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_out
);
    always_comb begin
        o_out = 1'b0;
        if (i_a[N-1] != i_b[N-1])
            o_out = ~i_a[N-1];
        else if (!i_a[N-1])
            o_out = (i_a[N-2:0] >= i_b[N-2:0]);
        else
            o_out = (i_a[N-2:0] <= i_b[N-2:0]);
    end
endmodule

module sm_sort_ctrl #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_data,
    output logic         o_busy
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t        state;
    logic [N-1:0]  mem [DEPTH];
    logic [IW-1:0] wr_idx, rd_idx, j, p;
    logic [IW-1:0] j_nxt;
    logic          ge, swap, last_j, last_pass, early_done;

    assign j_nxt     = j + IW'(1);
    assign last_j    = (j == IW'(DEPTH - 2) - p);
    assign last_pass = (p == IW'(DEPTH - 2));

    sm_ge #(.N(N)) u_ge (
        .i_a   (mem[j_nxt]),
        .i_b   (mem[j]),
        .o_out (ge)
    );

    assign swap = (state == SORT) && !ge;

`ifdef SM_SORT_EARLY_EXIT_EN
    logic swapped;
    // The pass is clean only if neither earlier compares nor the current one swapped.
    assign early_done = !(swapped || swap);
`else
    assign early_done = 1'b0;
`endif

    assign o_ready = i_rst_n && (state == LOAD);
    assign o_valid = (state == DRAIN);
    assign o_busy  = (state == SORT);
    assign o_data  = (state == DRAIN) ? mem[rd_idx] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= LOAD;
            wr_idx <= '0;
            rd_idx <= '0;
            j      <= '0;
            p      <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
`ifdef SM_SORT_EARLY_EXIT_EN
            swapped <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (i_valid) begin
                        mem[wr_idx] <= i_data;
                        if (wr_idx == IW'(DEPTH - 1)) begin
                            wr_idx <= '0;
                            state  <= SORT;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                SORT: begin
                    if (swap) begin
                        mem[j]     <= mem[j_nxt];
                        mem[j_nxt] <= mem[j];
                    end
`ifdef SM_SORT_EARLY_EXIT_EN
                    swapped <= last_j ? 1'b0 : (swapped || swap);
`endif
                    if (last_j) begin
                        j <= '0;
                        if (last_pass || early_done) begin
                            p     <= '0;
                            state <= DRAIN;
                        end else begin
                            p <= p + IW'(1);
                        end
                    end else begin
                        j <= j_nxt;
                    end
                end
                DRAIN: begin
                    if (i_ready) begin
                        if (rd_idx == IW'(DEPTH - 1)) begin
                            rd_idx <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_sort_ctrl.sv
// Directed bench for sm_sort_ctrl: ordering, latency, stalls, mid-sort reset and ignored inputs.
module tb_sm_sort_ctrl;
    localparam int N = 8;
    localparam int DEPTH = 4;
`ifdef SM_SORT_EARLY_EXIT_EN
    localparam int S_SORTED = 3;
`else
    localparam int S_SORTED = 6;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [N-1:0] i_data = '0;
    logic         o_ready, o_valid, o_busy;
    logic [N-1:0] o_data;
    int n_tests = 0;
    int n_fail = 0;
    int swaps;

    always #5 i_clk = ~i_clk;

    sm_sort_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_busy  (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the first SORT cycle.
    task automatic load(input logic [3:0][7:0] w);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check("load_ready", {31'd0, o_ready}, 1);
            i_valid = 1'b1;
            i_data  = w[k];
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic sort_wait(input int exp_s, input bit junk, output int nswap);
        int n;
        n = 0;
        nswap = 0;
        check("sort_busy", {31'd0, o_busy}, 1);
        check("sort_ready", {31'd0, o_ready}, 0);
        if (junk) begin
            i_valid = 1'b1;
            i_data  = 8'h11;
        end
        while (!o_valid && n < 50) begin
            if (dut.swap) nswap++;
            @(negedge i_clk);
            n++;
        end
        check("sort_cycles", n, exp_s);
    endtask

    task automatic drain(input logic [3:0][7:0] e, input int stall_at);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                i_ready = 1'b0;
                repeat (3) begin
                    @(negedge i_clk);
                    check("stall_valid", {31'd0, o_valid}, 1);
                    check("stall_data", o_data, e[k]);
                end
            end
            check("drain_valid", {31'd0, o_valid}, 1);
            check("drain_ready", {31'd0, o_ready}, 0);
            check("drain_data", o_data, e[k]);
            i_ready = 1'b1;
            @(negedge i_clk);
        end
        i_ready = 1'b0;
        i_valid = 1'b0;
        check("done_valid", {31'd0, o_valid}, 0);
        check("done_ready", {31'd0, o_ready}, 1);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        check("rst_ready", {31'd0, o_ready}, 0);
        check("rst_valid", {31'd0, o_valid}, 0);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_data", o_data, 0);
        i_rst_n = 1'b1;

        // Mixed signs and both zeros; junk input during SORT and DRAIN.
        load({8'h80, 8'h00, 8'h85, 8'h03});
        sort_wait(6, 1'b1, swaps);
        check("t1_swaps", swaps, 4);
        drain({8'h03, 8'h00, 8'h80, 8'h85}, -1);

        // Already sorted.
        load({8'h7F, 8'h05, 8'h00, 8'h81});
        sort_wait(S_SORTED, 1'b0, swaps);
        check("t2_swaps", swaps, 0);
        drain({8'h7F, 8'h05, 8'h00, 8'h81}, -1);

        // All equal: never swaps.
        load({8'h7F, 8'h7F, 8'h7F, 8'h7F});
        sort_wait(S_SORTED, 1'b0, swaps);
        check("t3_swaps", swaps, 0);
        drain({8'h7F, 8'h7F, 8'h7F, 8'h7F}, -1);

        // Stall mid-DRAIN.
        load({8'h81, 8'h01, 8'hFF, 8'h7F});
        sort_wait(6, 1'b0, swaps);
        check("t4_swaps", swaps, 4);
        drain({8'h7F, 8'h01, 8'h81, 8'hFF}, 2);

        // Reset in the 2nd SORT cycle.
        load({8'h22, 8'h91, 8'h33, 8'h44});
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_ready", {31'd0, o_ready}, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("t5_busy", {31'd0, o_busy}, 0);
        check("t5_valid", {31'd0, o_valid}, 0);
        check("t5_ready", {31'd0, o_ready}, 1);
        check("t5_data", o_data, 0);
        load({8'h00, 8'h7F, 8'h84, 8'h05});
        sort_wait(6, 1'b0, swaps);
        drain({8'h7F, 8'h05, 8'h00, 8'h84}, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
